rx_gearbox: RTL and testbench

//  Receive 64b/66b gearbox for the 10GBASE-R PCS: converts the continuous 32-bit transceiver word stream into
//  66-bit blocks presented as two 32-bit halves, with the 2-bit sync header alongside the first half.

---
 rtl/rx_gearbox.sv | 109 ++++++++++
 tb/tb_rx_gearbox.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_gearbox.sv
// 64b/66b receive gearbox: 32-bit raw words in, 66-bit blocks out as header+lo half then hi half.
// Latency 1 cycle (registered outputs); no backpressure, only i_valid gating; one stall per 33 valid inputs.
module rx_gearbox #(
   parameter int DATA_WIDTH   = 32,
   parameter int SLIP_HOLDOFF = 0
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_valid,
   input  logic                  i_slip,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [1:0]            o_header,
   output logic                  o_header_valid,
   output logic                  o_data_valid
);

   localparam int BUF_W  = DATA_WIDTH + 1;
   localparam int AV_W   = 2 * DATA_WIDTH + 1;
   localparam int HOLD_W = 16;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(SLIP_HOLDOFF);

   generate
      if (DATA_WIDTH != 32) begin : g_bad_width
         $error("rx_gearbox: only DATA_WIDTH = 32 is supported");
      end
   endgenerate

   typedef enum logic {
      PH_HEADER = 1'b0,
      PH_SECOND = 1'b1
   } phase_t;

   logic [BUF_W-1:0]  buf_q;
   logic [5:0]        fill_q;
   phase_t            phase_q;
   logic              slip_pend_q;
   logic [HOLD_W-1:0] holdoff_q;

   logic              slip_req;
   logic              slip_now;
   logic [AV_W-1:0]   avail_raw;
   logic [AV_W-1:0]   avail;
   logic [6:0]        avail_len;
   logic [6:0]        need;
   logic              emit;
   logic [AV_W-1:0]   remain;
   logic [6:0]        fill_nxt;

   // Buffer bits above fill are always zero, so new data can simply be OR-ed in above them.
   always_comb begin
      slip_req  = i_slip && (holdoff_q == '0);
      slip_now  = i_valid && (slip_pend_q || slip_req);
      avail_raw = ({{(AV_W-DATA_WIDTH){1'b0}}, i_data} << fill_q)
                | {{(AV_W-BUF_W){1'b0}}, buf_q};
      avail     = slip_now ? (avail_raw >> 1) : avail_raw;
      avail_len = {1'b0, fill_q} + (slip_now ? 7'd31 : 7'd32);
      need      = (phase_q == PH_HEADER) ? 7'd34 : 7'd32;
      emit      = i_valid && (avail_len >= need);
      remain    = emit ? (avail >> need) : avail;
      fill_nxt  = emit ? (avail_len - need) : avail_len;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         buf_q          <= '0;
         fill_q         <= '0;
         phase_q        <= PH_HEADER;
         slip_pend_q    <= 1'b0;
         holdoff_q      <= '0;
         o_data         <= '0;
         o_header       <= '0;
         o_header_valid <= 1'b0;
         o_data_valid   <= 1'b0;
      end else begin
         o_data_valid   <= emit;
         o_header_valid <= emit && (phase_q == PH_HEADER);

         if (emit) begin
            if (phase_q == PH_HEADER) begin
               o_header <= avail[1:0];
               o_data   <= avail[DATA_WIDTH+1:2];
            end else begin
               o_data   <= avail[DATA_WIDTH-1:0];
            end
         end

         if (i_valid) begin
            buf_q  <= BUF_W'(remain);
            fill_q <= 6'(fill_nxt);
            if (emit) begin
               phase_q <= (phase_q == PH_HEADER) ? PH_SECOND : PH_HEADER;
            end
         end

         // A slip never alters phase; holdoff only counts cycles that carry data.
         if (slip_now) begin
            slip_pend_q <= 1'b0;
            holdoff_q   <= HOLD_LOAD;
         end else begin
            slip_pend_q <= slip_pend_q || slip_req;
            if (i_valid && (holdoff_q != '0)) begin
               holdoff_q <= holdoff_q - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rx_gearbox.sv
// Bench for rx_gearbox: bit-queue reference model for two instances (holdoff 0 and 4)
// plus directed checks against the known 64b/66b test stream.
module tb_rx_gearbox;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        vld;
   logic        slp;
   logic [31:0] din;

   logic [31:0] od0, od4;
   logic [1:0]  oh0, oh4;
   logic        ohv0, ohv4, odv0, odv4;

   rx_gearbox #(.DATA_WIDTH(32), .SLIP_HOLDOFF(0)) dut0 (
      .i_clk(clk), .i_reset(rst), .i_data(din), .i_valid(vld), .i_slip(slp),
      .o_data(od0), .o_header(oh0), .o_header_valid(ohv0), .o_data_valid(odv0)
   );

   rx_gearbox #(.DATA_WIDTH(32), .SLIP_HOLDOFF(4)) dut4 (
      .i_clk(clk), .i_reset(rst), .i_data(din), .i_valid(vld), .i_slip(slp),
      .o_data(od4), .o_header(oh4), .o_header_valid(ohv4), .o_data_valid(odv4)
   );

   int ncomp = 0;
   int nfail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncomp++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: a plain FIFO of received bits per instance.
   bit          mbuf [2][0:127];
   int          mcnt [2];
   int          mphase [2];
   bit          mpend [2];
   int          mhold [2];
   int          hold_cfg [2] = '{0, 4};
   logic [31:0] edat [2];
   logic [1:0]  ehdr [2];
   logic        ehv [2];
   logic        edv [2];

   task automatic mpop(input int k, input int n);
      for (int i = 0; i < mcnt[k] - n; i++) mbuf[k][i] = mbuf[k][i+n];
      mcnt[k] -= n;
   endtask

   task automatic model_step(input int k, input logic v, input logic [31:0] d,
                             input logic s, input logic r);
      int need;
      bit acc;
      if (r) begin
         mcnt[k] = 0; mphase[k] = 0; mpend[k] = 0; mhold[k] = 0;
         edv[k] = 0; ehv[k] = 0; edat[k] = '0; ehdr[k] = '0;
         return;
      end
      edv[k] = 0;
      ehv[k] = 0;
      acc = mpend[k] || (s && mhold[k] == 0);
      if (!v) begin
         mpend[k] = acc;
         return;
      end
      for (int j = 0; j < 32; j++) mbuf[k][mcnt[k]+j] = d[j];
      mcnt[k] += 32;
      if (acc) begin
         mpop(k, 1);
         mpend[k] = 0;
         mhold[k] = hold_cfg[k];
      end else if (mhold[k] > 0) begin
         mhold[k]--;
      end
      need = (mphase[k] == 0) ? 34 : 32;
      if (mcnt[k] >= need) begin
         if (mphase[k] == 0) begin
            ehdr[k] = {mbuf[k][1], mbuf[k][0]};
            for (int j = 0; j < 32; j++) edat[k][j] = mbuf[k][j+2];
            ehv[k] = 1;
         end else begin
            for (int j = 0; j < 32; j++) edat[k][j] = mbuf[k][j];
         end
         edv[k] = 1;
         mpop(k, need);
         mphase[k] = 1 - mphase[k];
      end
   endtask

   // Known block stream: header 01, lo = A0000000+n, hi = B0000000+n.
   function automatic logic sbit(input int p);
      int b, o;
      logic [31:0] w;
      if (p < 0) return 1'b0;
      b = p / 66;
      o = p % 66;
      if (o == 0) return 1'b1;
      if (o == 1) return 1'b0;
      if (o < 34) begin
         w = 32'hA000_0000 + 32'(b);
         return w[o-2];
      end
      w = 32'hB000_0000 + 32'(b);
      return w[o-34];
   endfunction

   function automatic logic [31:0] sword(input int p);
      logic [31:0] r;
      for (int j = 0; j < 32; j++) r[j] = sbit(p + j);
      return r;
   endfunction

   bit chk_en;
   int oidx [2];
   int shift [2];
   int d0;
   int wcnt;

   task automatic scheck(input int k, input logic dv, input logic hv,
                         input logic [1:0] hdr, input logic [31:0] dat);
      int pos;
      if (!chk_en || !dv) return;
      pos = 66 * (oidx[k] / 2) + shift[k];
      if (oidx[k] % 2 == 0) begin
         chk($sformatf("s%0d_hv_first", k), hv, 1'b1);
         chk($sformatf("s%0d_hdr", k), hdr, {sbit(pos+1), sbit(pos)});
         chk($sformatf("s%0d_lo", k), dat, sword(pos+2));
      end else begin
         chk($sformatf("s%0d_hv_second", k), hv, 1'b0);
         chk($sformatf("s%0d_hi", k), dat, sword(pos+34));
      end
      oidx[k]++;
   endtask

   task automatic cmp(input int k, input logic dv, input logic hv,
                      input logic [1:0] hdr, input logic [31:0] dat);
      chk($sformatf("m%0d_dv", k), dv, edv[k]);
      chk($sformatf("m%0d_hv", k), hv, ehv[k]);
      chk($sformatf("m%0d_hdr", k), hdr, ehdr[k]);
      chk($sformatf("m%0d_dat", k), dat, edat[k]);
   endtask

   task automatic step(input logic v, input logic [31:0] d, input logic s, input logic r);
      vld = v; din = d; slp = s; rst = r;
      @(posedge clk);
      model_step(0, v, d, s, r);
      model_step(1, v, d, s, r);
      #1;
      cmp(0, odv0, ohv0, oh0, od0);
      cmp(1, odv4, ohv4, oh4, od4);
      scheck(0, odv0, ohv0, oh0, od0);
      scheck(1, odv4, ohv4, oh4, od4);
   endtask

   task automatic feed(input logic v, input logic s);
      logic [31:0] d;
      if (v) begin
         d = sword(32 * wcnt + d0);
         wcnt++;
      end else begin
         d = $urandom;
      end
      step(v, d, s, 1'b0);
   endtask

   task automatic restart_stream(input int delay, input bit en);
      wcnt = 0; d0 = delay; chk_en = en;
      oidx[0] = 0; oidx[1] = 0; shift[0] = 0; shift[1] = 0;
   endtask

   task automatic run_aligned(input string tag);
      int ndv;
      restart_stream(0, 1);
      for (int w = 0; w < 2; w++) begin
         ndv = 0;
         for (int i = 0; i < 33; i++) begin
            feed(1'b1, 1'b0);
            ndv += int'(odv0);
            if (w == 0 && i == 0) chk({tag, "_first_stall"}, odv0, 1'b0);
            if (w == 0 && i == 1) begin
               chk({tag, "_first_hv"}, ohv0, 1'b1);
               chk({tag, "_first_hdr"}, oh0, 2'b01);
               chk({tag, "_first_dat"}, od0, 32'hA000_0000);
            end
         end
         chk({tag, "_outs_per_33"}, ndv, 32);
      end
   endtask

   initial begin
      int  ndv, nsl;
      bit  found, locked, have_prev, sl;
      logic [31:0] prev_lo;
      rst = 1'b1; vld = 1'b0; slp = 1'b0; din = '0;
      restart_stream(0, 0);

      step(1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
      chk("rst_dv", odv0, 1'b0);
      chk("rst_hv", ohv0, 1'b0);
      chk("rst_hdr", oh0, 2'b00);
      chk("rst_dat", od0, 32'h0);

      // Aligned stream from reset.
      run_aligned("c1");

      // Slip requested while idle lands on the first valid cycle.
      feed(1'b0, 1'b1);
      chk("c4_idle_dv0", odv0, 1'b0);
      feed(1'b0, 1'b0);
      feed(1'b0, 1'b0);
      chk("c4_idle_dv2", odv0, 1'b0);
      shift[0]++; shift[1]++;
      for (int i = 0; i < 40; i++) feed(1'b1, 1'b0);

      // Holdoff: slips at t, t+2, t+6; the holdoff-4 instance ignores t+2.
      for (int i = 0; i < 7; i++) begin
         if (i == 0 || i == 6) begin shift[0]++; shift[1]++; end
         if (i == 2) shift[0]++;
         feed(1'b1, (i == 0 || i == 2 || i == 6));
      end
      for (int i = 0; i < 40; i++) feed(1'b1, 1'b0);

      // Valid toggling every cycle.
      step(1'b0, 32'h0, 1'b0, 1'b1);
      restart_stream(0, 1);
      ndv = 0;
      for (int i = 0; i < 132; i++) begin
         feed((i % 2 == 0), 1'b0);
         if (i % 2 == 1) chk("c3_no_out_after_idle", odv0, 1'b0);
         else ndv += int'(odv0);
      end
      chk("c3_outs_per_66", ndv, 64);

      // Reset mid SECOND phase with 17 buffered bits.
      step(1'b0, 32'h0, 1'b0, 1'b1);
      restart_stream(0, 1);
      for (int i = 0; i < 3; i++) feed(1'b1, 1'b0);
      shift[0]++; shift[1]++;
      feed(1'b1, 1'b1);
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         feed(1'b1, 1'b0);
         if (mcnt[0] == 17 && mphase[0] == 1) found = 1;
      end
      chk("c6_reached_fill17", found, 1'b1);
      step(1'b1, $urandom, 1'b1, 1'b1);
      chk("c6_rst_dv", odv0, 1'b0);
      chk("c6_rst_hv", ohv0, 1'b0);
      chk("c6_rst_dat", od0, 32'h0);
      chk("c6_rst_dv4", odv4, 1'b0);
      run_aligned("c6");

      // Stream missing its first 5 bits: slip until the header and payload signature line up.
      step(1'b0, 32'h0, 1'b0, 1'b1);
      restart_stream(5, 0);
      nsl = 0; sl = 0; locked = 0;
      for (int i = 0; i < 3000 && !locked; i++) begin
         feed(1'b1, sl);
         sl = 0;
         if (ohv0) begin
            if (oh0 == 2'b01 && od0[31:10] == {4'hA, 18'h0}) locked = 1;
            else begin sl = 1; nsl++; end
         end
      end
      chk("c2_locked", locked, 1'b1);
      chk("c2_slip_count", nsl, 61);
      have_prev = 0; prev_lo = '0;
      for (int i = 0; i < 70; i++) begin
         feed(1'b1, 1'b0);
         if (odv0 && ohv0) begin
            chk("c2_hdr", oh0, 2'b01);
            if (have_prev) chk("c2_lo_seq", od0, prev_lo + 32'd1);
            prev_lo = od0;
            have_prev = 1;
         end else if (odv0 && have_prev) begin
            chk("c2_hi", od0, prev_lo + 32'h1000_0000);
         end
      end

      // Random traffic against the model only.
      restart_stream(0, 0);
      step(1'b0, 32'h0, 1'b0, 1'b1);
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 3) != 0), $urandom,
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end

endmodule
